// File: rtl/mmio_console_pkg.sv
// mmio_console_pkg: shared window base, register offsets and STATUS bit positions.
package mmio_console_pkg;
    localparam logic [11:0] MMIO_BASE_HI = 12'h001;
    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_STATUS = 2'd1,
        REG_HALT   = 2'd2,
        REG_CYCLE  = 2'd3
    } reg_e;
    localparam int ST_EMPTY  = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_HALTED = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CMSB   = 4;
endpackage

// File: rtl/mmio_console_sync_fifo.sv
// sync_fifo: circular buffer with wrap-bit pointers and a sticky overflow flag.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_overflow
);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wp, r_rp;
    logic         r_ovf;
    logic         w_pop, w_push;
    assign o_empty    = r_wp == r_rp;
    assign o_full     = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop      = i_pop && !o_empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_push     = i_push && (!o_full || w_pop);
    assign o_overflow = r_ovf;
    assign o_dout     = o_empty ? '0 : r_mem[r_rp[AW-1:0]];
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            if (i_push && !w_push) r_ovf <= 1'b1;
        end
    end
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= i_din;
    end
endmodule

// File: rtl/mmio_console.sv
// mmio_console: console TX FIFO, status, cycle counter and halt register in the 0x001xxxxx window.
module mmio_console
    import mmio_console_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [29:0] MADDR,
    input  logic [3:0]  DMWE,
    input  logic        DMRE,
    input  logic [31:0] WDATA,
    output logic        SEL,
    output logic [31:0] RDATA,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic        HALT,
    output logic [7:0]  EXIT_CODE
);
    logic [31:0] r_rdata, r_cycle;
    logic        r_halt;
    logic [7:0]  r_exit;
    reg_e        w_reg;
    logic        w_push, w_halt_wr, w_full, w_empty, w_ovf, w_unused;
    logic [31:0] w_status, w_rd;
    assign SEL       = MADDR[29:18] == MMIO_BASE_HI;
    assign w_reg     = reg_e'(MADDR[1:0]);
    assign w_push    = SEL && w_reg == REG_TXDATA && DMWE[0];
    assign w_halt_wr = SEL && w_reg == REG_HALT && |DMWE && !r_halt;
    assign w_status  = 32'({w_full, w_ovf, r_halt, w_full, w_empty});
    assign w_rd      = w_reg == REG_STATUS ? w_status : w_reg == REG_CYCLE ? r_cycle : '0;
    assign w_unused  = ^{MADDR[17:2], WDATA[31:8]};
    assign TX_VALID  = !w_empty;
    assign RDATA     = r_rdata;
    assign HALT      = r_halt;
    assign EXIT_CODE = r_exit;
    sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
        .i_clk(CLK),
        .i_rst(RST),
        .i_push(w_push),
        .i_din(WDATA[7:0]),
        .i_pop(TX_READY),
        .o_dout(TX_DATA),
        .o_full(w_full),
        .o_empty(w_empty),
        .o_overflow(w_ovf)
    );
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rdata <= '0;
            r_cycle <= '0;
            r_halt  <= 1'b0;
            r_exit  <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
            if (SEL && DMRE) r_rdata <= w_rd;
            if (w_halt_wr) begin
                r_halt <= 1'b1;
                r_exit <= WDATA[7:0];
            end
        end
    end
endmodule

// File: tb/tb_mmio_console.sv
// tb_mmio_console: directed vectors, hand sequences and a queue-model random run for mmio_console.
module tb_mmio_console;
    logic        CLK = 1'b0, RST = 1'b0;
    logic [29:0] MADDR = '0;
    logic [3:0]  DMWE = '0;
    logic        DMRE = 1'b0, TX_READY = 1'b0;
    logic [31:0] WDATA = '0;
    logic        SEL, TX_VALID, HALT;
    logic [31:0] RDATA;
    logic [7:0]  TX_DATA, EXIT_CODE;
    int          n_pass = 0, n_total = 0, edge_cnt = 0, rel = 0;
    logic [7:0]  got[$], expq[$];
    typedef struct {
        logic [31:0] addr;
        logic        exp_sel;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t tbl[8];

    mmio_console dut (
        .CLK(CLK), .RST(RST), .MADDR(MADDR), .DMWE(DMWE), .DMRE(DMRE), .WDATA(WDATA),
        .SEL(SEL), .RDATA(RDATA), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
        .TX_READY(TX_READY), .HALT(HALT), .EXIT_CODE(EXIT_CODE)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) begin
        edge_cnt++;
        if (TX_VALID && TX_READY) got.push_back(TX_DATA);
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, a, e);
    endtask
    task automatic step();
        @(posedge CLK);
        #1;
    endtask
    task automatic wr(input logic [31:0] ba, input logic [3:0] be, input logic [31:0] d);
        MADDR = ba[31:2];
        DMWE = be;
        WDATA = d;
        step();
        DMWE = '0;
    endtask
    task automatic rd(input logic [31:0] ba);
        MADDR = ba[31:2];
        DMRE = 1'b1;
        step();
        DMRE = 1'b0;
    endtask
    task automatic do_reset();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        rel = edge_cnt;
        got.delete();
    endtask
    task automatic drain(input string nm);
        TX_READY = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!TX_VALID && got.size() >= expq.size()) break;
        end
        TX_READY = 1'b0;
        chk({nm, "_len"}, got.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            chk({nm, "_byte"}, (i < got.size()) ? got[i] : 8'h00, expq[i]);
        got.delete();
    endtask

    initial begin
        tbl[0] = '{32'h00100000, 1'b1, 1'b1, 32'h0};
        tbl[1] = '{32'h00100008, 1'b1, 1'b1, 32'h0};
        tbl[2] = '{32'h0017FFF4, 1'b1, 1'b1, 32'h1};
        tbl[3] = '{32'h00200004, 1'b0, 1'b1, 32'h1};
        tbl[4] = '{32'h00000004, 1'b0, 1'b1, 32'h1};
        tbl[5] = '{32'h001FFFF0, 1'b1, 1'b1, 32'h0};
        tbl[6] = '{32'h80100004, 1'b0, 1'b1, 32'h0};
        tbl[7] = '{32'h0010FFF4, 1'b1, 1'b1, 32'h1};

        // async reset: outputs clear before any clock edge
        #1 RST = 1'b1;
        #1;
        chk("rst_txvalid", TX_VALID, 0);
        chk("rst_txdata", TX_DATA, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_halt", HALT, 0);
        chk("rst_exit", EXIT_CODE, 0);
        step();
        step();
        RST = 1'b0;
        rel = edge_cnt;
        for (int i = 0; i < 10; i++) step();
        rd(32'h0010000C);
        chk("cycle_after_10", RDATA, 10);

        TX_READY = 1'b1;
        got.delete();
        wr(32'h00100000, 4'b0001, 32'h41);
        wr(32'h00100000, 4'b0001, 32'h42);
        wr(32'h00100000, 4'b0001, 32'h43);
        for (int i = 0; i < 3; i++) step();
        TX_READY = 1'b0;
        expq = '{8'h41, 8'h42, 8'h43};
        chk("stream_len", got.size(), 3);
        for (int i = 0; i < 3; i++) chk("stream_byte", (i < got.size()) ? got[i] : 8'h00, expq[i]);
        got.delete();
        rd(32'h00100004);
        chk("status_empty", RDATA, 32'h01);

        for (int i = 0; i < 8; i++) begin
            MADDR = tbl[i].addr[31:2];
            DMRE = 1'b1;
            #1;
            chk("tbl_sel", SEL, tbl[i].exp_sel);
            step();
            DMRE = 1'b0;
            if (tbl[i].chk_rd) chk("tbl_rdata", RDATA, tbl[i].exp_rd);
        end

        for (int i = 0; i < 9; i++) wr(32'h00100000, 4'b0001, 32'h30 + i);
        chk("ovf_txdata_head", TX_DATA, 8'h30);
        rd(32'h00100004);
        chk("status_full_ovf", RDATA, 32'h1A);
        expq = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
        drain("ovf_drain");

        do_reset();
        for (int i = 0; i < 8; i++) wr(32'h00100000, 4'b0001, 32'h60 + i);
        MADDR = 30'(32'h00100000 >> 2);
        DMWE = 4'b0001;
        WDATA = 32'h55;
        TX_READY = 1'b1;
        step();
        DMWE = '0;
        TX_READY = 1'b0;
        rd(32'h00100004);
        chk("status_full_no_ovf", RDATA, 32'h12);
        expq = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h55};
        drain("pushpop_drain");
        rd(32'h00100004);
        chk("status_after_pushpop", RDATA, 32'h01);

        wr(32'h00200008, 4'hF, 32'h11);
        chk("outside_halt", HALT, 0);
        wr(32'h00000000, 4'hF, 32'h77);
        chk("outside_tx", TX_VALID, 0);
        wr(32'h00100008, 4'b0001, 32'h0000002A);
        chk("halt_set", HALT, 1);
        chk("exit_code", EXIT_CODE, 8'h2A);
        wr(32'h00100008, 4'hF, 32'h07);
        chk("exit_sticky", EXIT_CODE, 8'h2A);
        rd(32'h00100004);
        chk("status_halted", RDATA, 32'h05);
        wr(32'h00100000, 4'b0001, 32'h99);
        chk("tx_after_halt_v", TX_VALID, 1);
        chk("tx_after_halt_d", TX_DATA, 8'h99);

        for (int i = 0; i < 3; i++) wr(32'h00100000, 4'b0001, 32'hA0 + i);
        TX_READY = 1'b1;
        step();
        #3 RST = 1'b1;
        #1;
        chk("midrst_txvalid", TX_VALID, 0);
        chk("midrst_halt", HALT, 0);
        chk("midrst_exit", EXIT_CODE, 0);
        TX_READY = 1'b0;
        step();
        RST = 1'b0;
        rel = edge_cnt;
        got.delete();
        rd(32'h0010000C);
        chk("cycle_restart", RDATA, 0);
        rd(32'h00100004);
        chk("status_after_rst", RDATA, 32'h01);

        begin
            logic [7:0]  q[$];
            logic        ovf, inwin, rdq, rdy, push, pop;
            logic [31:0] exp_rd, status, data;
            logic [11:0] hi;
            logic [1:0]  regv;
            logic [3:0]  be;
            do_reset();
            ovf = 1'b0;
            exp_rd = 32'h0;
            for (int c = 0; c < 400; c++) begin
                inwin = $urandom_range(0, 7) != 0;
                hi = 12'($urandom);
                if (hi == 12'h001) hi = 12'h7FF;
                regv = 2'($urandom);
                be = (regv == 2'd2) ? 4'h0 : 4'($urandom);
                rdq = 1'($urandom);
                rdy = $urandom_range(0, 2) == 0;
                data = $urandom;
                status = (q.size() == 8 ? 32'h12 : 32'h0) | (ovf ? 32'h08 : 32'h0) |
                         (q.size() == 0 ? 32'h01 : 32'h0);
                pop = rdy && q.size() > 0;
                push = inwin && regv == 2'd0 && be[0];
                MADDR = {inwin ? 12'h001 : hi, 16'($urandom), regv};
                DMWE = be;
                DMRE = rdq;
                WDATA = data;
                TX_READY = rdy;
                #1;
                chk("rnd_sel", SEL, inwin);
                step();
                if (pop) void'(q.pop_front());
                if (push) begin
                    if (q.size() < 8) q.push_back(data[7:0]);
                    else ovf = 1'b1;
                end
                if (inwin && rdq)
                    exp_rd = regv == 2'd1 ? status : regv == 2'd3 ? 32'(edge_cnt - rel - 1) : 32'h0;
                chk("rnd_txvalid", TX_VALID, q.size() != 0);
                if (q.size() != 0) chk("rnd_txdata", TX_DATA, q[0]);
                chk("rnd_rdata", RDATA, exp_rd);
            end
            DMWE = '0;
            DMRE = 1'b0;
            TX_READY = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
